// File: rtl/mcr_loader_pkg.sv
// Shared types and constants for the MCR1 ROM loader.
package mcr_loader_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_e;

    localparam logic [7:0] IDX_ROM   = 8'd0;
    localparam logic [7:0] IDX_MOD   = 8'd1;
    localparam logic [7:0] IDX_NVRAM = 8'd4;
    localparam logic [7:0] IDX_DIP   = 8'd254;

endpackage

// File: rtl/mcr_reset_timer.sv
// Loadable 16-bit down-counter used to stretch core reset; stops at zero.
module mcr_reset_timer #(
    parameter logic [15:0] INIT = 16'hFFFF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic        dec_i,
    output logic        done_o
);

    logic [15:0] cnt_q, cnt_d;

    // Next count: load wins over decrement, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = INIT;
        else if (dec_i && cnt_q != 16'd0)
            cnt_d = cnt_q - 16'd1;
    end

    // Counter register, reset to the full hold value.
    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            cnt_q <= INIT;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == 16'd0);

endmodule

// File: rtl/mcr_rom_loader.sv
// HPS ioctl sequencer for MCR1: ROM staging, port-A mux, mod/DIP capture and
// core reset sequencing. Optional NVRAM path enabled by `define MCR_NVRAM_EN.
module mcr_rom_loader
    import mcr_loader_pkg::*;
#(
    parameter logic [15:0] RST_HOLD = 16'hFFFF,
    parameter int          NV_AW    = 11
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              user_reset,
    input  logic [14:0]       cpu_rom_addr,
    output logic              rom_we,
    output logic [15:0]       rom_addr,
    output logic [7:0]        rom_d,
    output logic              core_reset,
    output logic              rom_loaded,
    output logic [7:0]        mod_id,
`ifdef MCR_NVRAM_EN
    input  logic              ioctl_upload,
    output logic [7:0]        ioctl_din,
    output logic              nvram_we,
    output logic [NV_AW-1:0]  nvram_addr,
    output logic [7:0]        nvram_d,
    input  logic [7:0]        nvram_q,
`endif
    output logic [63:0]       dip_sw
);

    state_e      state_q, state_d;
    logic        rom_dl, rom_dl_q, dl_rise, dl_fall;
    logic        tmr_load, tmr_dec, tmr_done;
    logic        stage_rom, stage_nv;
    logic        buf_vld_q, buf_nv_q, buf_rom;
    logic [15:0] buf_addr_q;
    logic [7:0]  buf_dat_q;
    logic        rom_loaded_q;
    logic [7:0]  mod_q;
    logic [63:0] dip_q;

    assign rom_dl  = ioctl_download && (ioctl_index == IDX_ROM);
    assign dl_rise = rom_dl && !rom_dl_q;
    assign dl_fall = !rom_dl && rom_dl_q;

    assign stage_rom = ioctl_wr && rom_dl && (ioctl_addr[24:16] == 9'd0);
`ifdef MCR_NVRAM_EN
    assign stage_nv  = ioctl_wr && ioctl_download && (ioctl_index == IDX_NVRAM);
`else
    assign stage_nv  = 1'b0;
`endif

    mcr_reset_timer #(.INIT(RST_HOLD)) u_timer (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .load_i  (tmr_load),
        .dec_i   (tmr_dec),
        .done_o  (tmr_done)
    );

    // Reset sequencing FSM; a new ROM download overrides everything.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_EMPTY: ;
            ST_LOAD: begin
                if (dl_fall) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (user_reset)    tmr_load = 1'b1;
                else if (tmr_done) state_d  = ST_RUN;
                else               tmr_dec  = 1'b1;
            end
            ST_RUN: begin
                if (user_reset) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (dl_rise) begin
            state_d  = ST_LOAD;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end
    end

    // State, edge detector and loaded flag.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            rom_dl_q     <= 1'b0;
            rom_loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rom_dl_q <= rom_dl;
            if (state_q == ST_LOAD && dl_fall)
                rom_loaded_q <= 1'b1;
        end
    end

    // One-entry staging buffer plus mod/DIP capture; buffer drains every cycle.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            buf_vld_q  <= 1'b0;
            buf_nv_q   <= 1'b0;
            buf_addr_q <= 16'd0;
            buf_dat_q  <= 8'd0;
            mod_q      <= 8'd0;
            dip_q      <= 64'd0;
        end else begin
            buf_vld_q <= stage_rom || stage_nv;
            if (stage_rom || stage_nv) begin
                buf_nv_q   <= stage_nv;
                buf_addr_q <= ioctl_addr[15:0];
                buf_dat_q  <= ioctl_dout;
            end
            if (ioctl_wr && ioctl_download && ioctl_index == IDX_MOD)
                mod_q <= ioctl_dout;
            if (ioctl_wr && ioctl_download && ioctl_index == IDX_DIP &&
                ioctl_addr[24:3] == 22'd0)
                dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

    // A pending ROM byte keeps port A even if the FSM just left LOAD.
    assign buf_rom    = buf_vld_q && !buf_nv_q;
    assign rom_we     = buf_rom;
    assign rom_addr   = (state_q == ST_LOAD || buf_rom) ? buf_addr_q : {1'b0, cpu_rom_addr};
    assign rom_d      = buf_dat_q;
    assign core_reset = (state_q != ST_RUN);
    assign rom_loaded = rom_loaded_q;
    assign mod_id     = mod_q;
    assign dip_sw     = dip_q;

`ifdef MCR_NVRAM_EN
    logic        up_act, up_new, up_seen_q, up_wait_q;
    logic [24:0] up_addr_q;
    logic [7:0]  din_q;

    assign up_act = ioctl_upload && (ioctl_index == IDX_NVRAM);
    assign up_new = up_act && (!up_seen_q || ioctl_addr != up_addr_q);

    // Upload tracking: each new address stalls HPS for two cycles of RAM read.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            up_seen_q <= 1'b0;
            up_wait_q <= 1'b0;
            up_addr_q <= 25'd0;
            din_q     <= 8'd0;
        end else begin
            up_seen_q <= up_act;
            up_wait_q <= up_new;
            if (up_new) up_addr_q <= ioctl_addr;
            if (up_act) din_q     <= nvram_q;
        end
    end

    assign ioctl_wait = buf_vld_q || up_new || up_wait_q;
    assign ioctl_din  = din_q;
    assign nvram_we   = buf_vld_q && buf_nv_q;
    assign nvram_addr = up_act ? ioctl_addr[NV_AW-1:0] : buf_addr_q[NV_AW-1:0];
    assign nvram_d    = buf_dat_q;
`else
    assign ioctl_wait = buf_vld_q;
`endif

endmodule

// File: tb/tb_mcr_rom_loader.sv
// Directed bench for mcr_rom_loader (default build, RST_HOLD=16).
module tb_mcr_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        user_reset;
    logic [14:0] cpu_rom_addr;
    logic        rom_we;
    logic [15:0] rom_addr;
    logic [7:0]  rom_d;
    logic        core_reset;
    logic        rom_loaded;
    logic [7:0]  mod_id;
    logic [63:0] dip_sw;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    mcr_rom_loader #(.RST_HOLD(16'd16), .NV_AW(11)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .user_reset     (user_reset),
        .cpu_rom_addr   (cpu_rom_addr),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_d          (rom_d),
        .core_reset     (core_reset),
        .rom_loaded     (rom_loaded),
        .mod_id         (mod_id),
        .dip_sw         (dip_sw)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stage one byte, then check the commit cycle and the idle cycle after it.
    task automatic rom_write(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0;
        chk("wr_we",   {63'd0, rom_we}, 64'd1);
        chk("wr_addr", {48'd0, rom_addr}, {48'd0, a[15:0]});
        chk("wr_d",    {56'd0, rom_d}, {56'd0, d});
        chk("wr_wait", {63'd0, ioctl_wait}, 64'd1);
        step();
        chk("wr_we_off",   {63'd0, rom_we}, 64'd0);
        chk("wr_wait_off", {63'd0, ioctl_wait}, 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = 25'd0; ioctl_dout = 8'd0; user_reset = 1'b0; cpu_rom_addr = 15'd0;

        // 1: reset values
        step(); step();
        chk("rst_we",     {63'd0, rom_we}, 64'd0);
        chk("rst_addr",   {48'd0, rom_addr}, 64'd0);
        chk("rst_d",      {56'd0, rom_d}, 64'd0);
        chk("rst_wait",   {63'd0, ioctl_wait}, 64'd0);
        chk("rst_creset", {63'd0, core_reset}, 64'd1);
        chk("rst_loaded", {63'd0, rom_loaded}, 64'd0);
        chk("rst_mod",    {56'd0, mod_id}, 64'd0);
        chk("rst_dip",    dip_sw, 64'd0);
        reset_n = 1'b1;
        cpu_rom_addr = 15'h1234;
        step();
        chk("empty_mux",  {48'd0, rom_addr}, 64'h1234);
        chk("empty_crst", {63'd0, core_reset}, 64'd1);

        // 2: ROM download, loader owns port A
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        step();
        chk("load_mux", {48'd0, rom_addr}, 64'h0000);
        rom_write(25'h0000, 8'hA5);
        rom_write(25'h0001, 8'h5A);
        rom_write(25'h8000, 8'hC3);

        // 3: out-of-range address dropped
        ioctl_addr = 25'h10000; ioctl_dout = 8'hFF; ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0;
        chk("oor_we",   {63'd0, rom_we}, 64'd0);
        chk("oor_wait", {63'd0, ioctl_wait}, 64'd0);
        chk("oor_addr", {48'd0, rom_addr}, 64'h8000);

        // 4: last byte staged just before download ends, then hold count
        ioctl_addr = 25'h0002; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        chk("last_we",   {63'd0, rom_we}, 64'd1);
        chk("last_addr", {48'd0, rom_addr}, 64'h0002);
        chk("last_d",    {56'd0, rom_d}, 64'h77);
        step();
        chk("end_loaded", {63'd0, rom_loaded}, 64'd1);
        chk("end_crst",   {63'd0, core_reset}, 64'd1);
        chk("end_we",     {63'd0, rom_we}, 64'd0);
        chk("hold_mux",   {48'd0, rom_addr}, 64'h1234);
        n = 0;
        while (core_reset && n < 100) begin step(); n++; end
        chk("hold_len", 64'(n), 64'd17);
        cpu_rom_addr = 15'h7ABC;
        #1;
        chk("run_mux", {48'd0, rom_addr}, 64'h7ABC);

        // 6: DIP and mod capture while running
        ioctl_download = 1'b1; ioctl_index = 8'd254;
        ioctl_addr = 25'd2; ioctl_dout = 8'h3C; ioctl_wr = 1'b1;
        step();
        chk("dip_val", dip_sw, 64'h0000_0000_003C_0000);
        chk("dip_we",  {63'd0, rom_we}, 64'd0);
        ioctl_addr = 25'd8; ioctl_dout = 8'hFF;
        step();
        chk("dip_oor", dip_sw, 64'h0000_0000_003C_0000);
        ioctl_index = 8'd1; ioctl_addr = 25'h1F0; ioctl_dout = 8'h01;
        step();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        chk("mod_val",  {56'd0, mod_id}, 64'h01);
        chk("mod_crst", {63'd0, core_reset}, 64'd0);

        // 5: user reset pulse from RUN
        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
        n = 0;
        while (core_reset && n < 100) begin step(); n++; end
        chk("ureset_len", 64'(n), 64'd17);
        chk("ureset_mod", {56'd0, mod_id}, 64'h01);
        chk("ureset_dip", dip_sw, 64'h0000_0000_003C_0000);

        // reload from RUN, then reset_n while a byte is being staged
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        step();
        chk("reload_crst", {63'd0, core_reset}, 64'd1);
        ioctl_addr = 25'h0010; ioctl_dout = 8'h99; ioctl_wr = 1'b1; reset_n = 1'b0;
        step();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        chk("midrst_we",     {63'd0, rom_we}, 64'd0);
        chk("midrst_wait",   {63'd0, ioctl_wait}, 64'd0);
        chk("midrst_loaded", {63'd0, rom_loaded}, 64'd0);
        chk("midrst_mod",    {56'd0, mod_id}, 64'd0);
        chk("midrst_dip",    dip_sw, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
